// File: rtl/imem_pkg.sv
// imem_pkg: shared widths, default program limit and loader FSM states.
package imem_pkg;
  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;
  localparam int MAX_WORDS_DEF = 256;
  typedef enum logic [1:0] {IDLE, LOAD, CHECK, FIN} state_t;
endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: assembles little-endian bytes into words; word_valid is combinational with the 4th byte.
module byte_packer
  import imem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              bvalid,
  input  logic [BYTE_W-1:0] bdata,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);
  logic [1:0] cnt;
  logic [WORD_W-BYTE_W-1:0] part;
  assign word_valid = bvalid && cnt == 2'd3;
  assign word = {bdata, part};
  // Shifting in from the top leaves byte 0 in the low lane once three bytes are held.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
      part <= '0;
    end else if (bvalid) begin
      cnt <= cnt + 2'd1;
      part <= {bdata, part[WORD_W-BYTE_W-1:BYTE_W]};
    end
  end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams bytes into instruction memory words; LOADER_CHECKSUM_EN adds a trailer-sum check.
module imem_loader
  import imem_pkg::*;
#(
  parameter logic [WORD_W-1:0] BASE_ADDR = 32'h0000_0000,
  parameter int MAX_WORDS = MAX_WORDS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [8:0]        len_words,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error
);
  state_t state;
  logic [8:0] len, wcnt;
  logic accept, too_big, wv;
  logic [WORD_W-1:0] word;
`ifdef LOADER_CHECKSUM_EN
  localparam state_t AFTER = CHECK;
  logic [WORD_W-1:0] sum;
`else
  localparam state_t AFTER = FIN;
`endif
  assign accept = state == IDLE && start;
  assign too_big = int'(len_words) > MAX_WORDS;
  assign in_ready = state == LOAD || state == CHECK;
  assign busy = state != IDLE;
  assign done = state == FIN;
  byte_packer u_packer (
    .clk(clk),
    .rst(rst),
    .clr(accept),
    .bvalid(in_valid && in_ready),
    .bdata(in_data),
    .word_valid(wv),
    .word(word)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      len <= '0;
      wcnt <= '0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      error <= 1'b0;
    end else begin
      mem_we <= wv && state == LOAD;
      case (state)
        IDLE: if (start) begin
          len <= len_words;
          wcnt <= '0;
          error <= too_big;
          state <= (len_words == 9'd0 || too_big) ? FIN : LOAD;
        end
        LOAD: if (wv) begin
          mem_addr <= BASE_ADDR + {21'd0, wcnt, 2'b00};
          mem_wdata <= word;
          wcnt <= wcnt + 9'd1;
          if (wcnt + 9'd1 == len) state <= AFTER;
        end
`ifdef LOADER_CHECKSUM_EN
        CHECK: if (wv) begin
          error <= word != sum;
          state <= FIN;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst || accept) sum <= '0;
    else if (wv && state == LOAD) sum <= sum + word;
  end
`endif
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized loads against a queue-based model with a decoupled write monitor.
module tb_imem_loader;
  localparam logic [31:0] BASE = 32'hFFFF_FFF0;
  logic clk = 1'b0, rst, start, in_valid, in_ready, mem_we, busy, done, error;
  logic [8:0] len_words;
  logic [7:0] in_data;
  logic [31:0] mem_addr, mem_wdata;
  int checks = 0, errors = 0, dones = 0, writes = 0, readies = 0, acc = 0;
  bit prev4 = 0, armed = 0;
  logic [31:0] la = 0, ld = 0;
  typedef struct {logic [31:0] a; logic [31:0] d;} wr_t;
  wr_t q[$];
  wr_t e;
  logic [7:0] prog[$];

  always #5 clk = ~clk;

  imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(256)) dut (
    .clk(clk), .rst(rst), .start(start), .len_words(len_words),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .error(error)
  );

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every write must match the oldest expected write and follow a 4th-byte acceptance.
  always @(negedge clk) begin
    if (mem_we) begin
      writes++;
      chk("we_after_4th_byte", 32'(prev4), 1);
      if (q.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        e = q.pop_front();
        chk("addr", mem_addr, e.a);
        chk("data", mem_wdata, e.d);
        la = e.a;
        ld = e.d;
      end
    end else if (armed) begin
      chk("hold_addr", mem_addr, la);
      chk("hold_data", mem_wdata, ld);
    end
    if (done) dones++;
    if (in_ready) readies++;
    prev4 = in_valid && in_ready && acc % 4 == 3;
    if (rst || (start && !busy)) acc = 0;
    else if (in_valid && in_ready) acc++;
    if (rst) begin
      armed = 1;
      la = 0;
      ld = 0;
    end
  end

  task automatic send(input logic [7:0] b, input bit gaps, input bit poke);
    if (gaps) begin
      in_valid = 0;
      in_data = 8'($urandom);
      step();
    end
    in_valid = 1;
    in_data = b;
    if (poke) begin
      start = 1;
      len_words = 0;
    end
    @(negedge clk);
    chk("in_ready_loading", 32'(in_ready), 1);
    step();
    start = 0;
    in_valid = 0;
  endtask

  task automatic do_load(input int len, input bit gaps, input bit poke, input bit bad);
    int d0, w0, r0, n;
    logic [31:0] w, sum;
    logic [7:0] b;
    bit exp_err;
    d0 = dones;
    w0 = writes;
    sum = 0;
    exp_err = len > 256;
    start = 1;
    len_words = 9'(len);
    step();
    start = 0;
    len_words = 9'($urandom);
    if (len > 256) begin
      r0 = readies;
      in_valid = 1;
      in_data = 8'($urandom);
      repeat (6) step();
      in_valid = 0;
      chk("no_ready_too_long", 32'(readies - r0), 0);
    end else begin
      for (int i = 0; i < len; i++) begin
        for (int k = 0; k < 4; k++) begin
          b = (i * 4 + k < prog.size()) ? prog[i * 4 + k] : 8'($urandom);
          w[8 * k +: 8] = b;
          send(b, gaps, poke && i == 0 && k == 2);
        end
        q.push_back('{BASE + 32'(4 * i), w});
        sum += w;
      end
`ifdef LOADER_CHECKSUM_EN
      if (len > 0) begin
        w = bad ? sum + 32'd1 : sum;
        for (int k = 0; k < 4; k++) send(w[8 * k +: 8], gaps, 1'b0);
        exp_err = bad;
      end
`endif
    end
    n = 0;
    while (busy && n < 20) begin
      step();
      n++;
    end
    chk("finish_timeout", 32'(n < 20), 1);
    step();
    chk("done_once", 32'(dones - d0), 1);
    chk("write_count", 32'(writes - w0), len > 256 ? 0 : 32'(len));
    chk("error", 32'(error), 32'(exp_err));
    chk("queue_empty", 32'(q.size()), 0);
  endtask

  initial begin
    rst = 1;
    start = 0;
    in_valid = 0;
    in_data = 0;
    len_words = 0;
    repeat (2) step();
    rst = 0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", mem_wdata, 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    prog = '{8'h93, 8'h0A, 8'h10, 8'h00, 8'hB3, 8'h83, 8'h62, 8'h00};
    do_load(2, 0, 0, 0);
    do_load(2, 1, 1, 1);
    prog.delete();
    do_load(300, 0, 0, 0);
    do_load(0, 0, 0, 0);
    start = 1;
    len_words = 2;
    step();
    start = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) q.push_back('{BASE, {8'h44, 8'h33, 8'h22, 8'h11}});
      send(8'h11 * 8'(i + 1), 0, 0);
    end
    rst = 1;
    step();
    rst = 0;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_addr", mem_addr, 0);
    chk("midrst_data", mem_wdata, 0);
    chk("midrst_queue", 32'(q.size()), 0);
    prog = '{8'h13, 8'h00, 8'h00, 8'h00};
    do_load(1, 0, 0, 0);
    prog.delete();
    repeat (25) begin
      int l;
      l = $urandom_range(0, 8);
      do_load(l, 1'($urandom_range(0, 1)), l > 0 && $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, byte address of the first loaded word.
REQ-002 Parameter MAX_WORDS, default 256, largest accepted program length in words.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle request to begin a load; sampled only in IDLE.
REQ-006 len_words  input  9  program length in words; latched when start is accepted.
REQ-007 in_valid  input  1  byte-stream valid.
REQ-008 in_data  input  8  byte-stream data, little-endian within each word.
REQ-009 in_ready  output  1  byte-stream ready.
REQ-010 mem_we  output  1  instruction-memory write enable, one-cycle pulse per word.
REQ-011 mem_addr  output  32  instruction-memory byte address of the word being written.
REQ-012 mem_wdata  output  32  assembled instruction word.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse when a load completes.
REQ-015 error  output  1  load-failure flag, held until the next accepted start.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, CHECK and FIN.
REQ-017 IDLE + start: latch len_words, clear error, clear the word counter and byte counter, then go to LOAD.
REQ-018 Start with len_words==0: go to FIN with no writes and no bytes accepted.
REQ-019 Start with len_words>MAX_WORDS: set error, go to FIN, perform no writes.
REQ-020 in_ready SHALL be 1 only in LOAD and CHECK; a byte transfers on a cycle where in_valid && in_ready.
REQ-021 Byte k (0..3) of a word SHALL occupy bits [8k+7:8k] of the word.
REQ-022 In the cycle after the 4th byte of word n is accepted, mem_we=1, mem_addr=BASE_ADDR+4*n (mod 2^32), mem_wdata=assembled word.
REQ-023 mem_we SHALL never stay high for two consecutive cycles on the same word.
REQ-024 in_ready stays high during the write cycle, giving a sustained throughput of 1 byte per cycle.
REQ-025 After word len-1 is accepted: go to CHECK if LOADER_CHECKSUM_EN is defined, otherwise go to FIN.
REQ-026 FIN: pulse done for one cycle and return to IDLE. The final mem_we pulse and done may coincide.
REQ-027 start asserted outside IDLE SHALL be ignored.
REQ-028 mem_addr and mem_wdata SHALL hold their last values when mem_we=0.

Reset
REQ-029 On rst: state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0; all counters and the checksum are cleared.
REQ-030 Reset mid-load: any partially assembled word is discarded and no further mem_we is issued.

Configuration
REQ-031 Macro LOADER_CHECKSUM_EN defined:
- A running 32-bit sum (mod 2^32) of all written words is kept.
- CHECK accepts 4 more bytes as a little-endian trailer word; these bytes are never written to memory.
- If the trailer differs from the sum, error=1; then go to FIN.
REQ-032 Macro LOADER_CHECKSUM_EN undefined: no CHECK state, no sum register; error is raised only per REQ-019.

Structure
REQ-033 Shared package imem_pkg SHALL hold the FSM state enum, WORD_W=32, BYTE_W=8 and the default MAX_WORDS.
REQ-034 Sub-module byte_packer SHALL own byte-to-word assembly. It takes byte valid/data and outputs a one-cycle word_valid with the packed word; it is cleared by rst and by start.

Verification
REQ-035 len=2, bytes 93 0A 10 00 B3 83 62 00 -> writes 0x00100A93@0x0, 0x006283B3@0x4; done pulses once; error=0.
REQ-036 in_valid toggled 1-0-1-0 over the same stream -> identical writes; mem_we only on cycles following a 4th-byte acceptance.
REQ-037 len=300 with MAX_WORDS=256 -> error=1, done pulses, zero mem_we, in_ready never asserted.
REQ-038 rst asserted after 2 bytes of word 1, then restart with len=1 and bytes 13 00 00 00 -> a single write of 0x00000013@BASE_ADDR.
REQ-039 With LOADER_CHECKSUM_EN: words 0x1 and 0x2 with trailer 0x3 -> error=0; the same words with trailer 0x4 -> error=1; exactly two writes in both cases.
REQ-040 start pulsed while busy, and len=0 start -> the active load is unaffected; len=0 gives done the cycle after FIN entry, with no writes.
